pwm_ramp_adc: RTL and testbench
===============================

# pwm_ramp_adc

- Front end of the PWM-based ADC, directly upstream of the averaging subsystem.
- Drives a PWM DAC (external RC filter) with a slow duty-cycle sawtooth ramp and watches the external comparator.
- Captures the 8-bit duty code at which the filtered ramp crosses the analog input.
- Emits that code as `sample` with a one-cycle `sample_valid` strobe; `sample` feeds the averager's `Din` and `sample_valid` drives its `EN`.

## Interface
- `SETTLE_PERIODS`, default 1: PWM periods held at each duty code before stepping; legal range 1..255.
- `DISCHARGE_PERIODS`, default 4: PWM periods with output forced low between conversions; legal range 1..255.
- `clk` input, 1: system clock; single clock domain.
- `reset` input, 1: asynchronous, active-high reset.
- `enable` input, 1: run conversions when high.
- `comp_in` input, 1: asynchronous comparator output; high means ramp voltage ≥ analog input.
- `pwm_out` output, 1: registered PWM drive to the RC filter.
- `sample` output, 8: last captured duty code.
- `sample_valid` output, 1: one-cycle strobe; `sample` is new on this cycle.
- `overrange` output, 1: qualifies the most recent sample; high if the ramp reached full scale without a comparator trip.

## Operation
- **Synchronizer.** `comp_in` passes through a 2-flop synchronizer to give `comp_s`. Raw `comp_in` is never used.
- **PWM counter.** `pwm_cnt` is 8 bits and increments every cycle while `enable` is high, wrapping 255→0.
  - "Period end" is any cycle with `pwm_cnt` == 255.
  - The PWM period is fixed at 256 clocks.
- **PWM output.** `pwm_out` is registered: `pwm_out` <= (state == RAMP) && (`pwm_cnt` < `duty`).
  - High-time per period is exactly `duty` clocks (0..255 of 256).
- **States:** IDLE, DISCHARGE, RAMP.
- **IDLE**
  - `pwm_out` is 0; `pwm_cnt`, `period_cnt` and `duty` are held at 0.
  - Leaves when `enable` = 1: goes to DISCHARGE with `pwm_cnt` = 0.
- **DISCHARGE**
  - `pwm_out` is 0 and `duty` is 0; `comp_s` is ignored.
  - Counts period ends. At the `DISCHARGE_PERIODS`-th period end it goes to RAMP with `period_cnt` = 0.
- **RAMP, comparator trip** (priority 1)
  - If `comp_s` = 1: `sample` <= `duty`, `overrange` <= 0, `sample_valid` <= 1.
  - Then: go to DISCHARGE, `pwm_cnt` <= 0, `duty` <= 0, `period_cnt` <= 0.
- **RAMP, duty step** (priority 2)
  - At a period end, if `period_cnt` == `SETTLE_PERIODS`−1: `period_cnt` <= 0 and `duty` <= `duty`+1.
  - Otherwise at a period end: `period_cnt` increments.
- **RAMP, overrange** (priority 3)
  - If a duty step is due while `duty` == 255 and `comp_s` = 0: `sample` <= 255, `overrange` <= 1, `sample_valid` <= 1.
  - Then: go to DISCHARGE with the same counter clears as a trip. `duty` never wraps.
- **Simultaneous events.** A trip and a duty step in the same cycle: the trip wins and captures the pre-step `duty`.
- **Disable.** `enable` = 0 in any state moves to IDLE on the next edge.
  - No `sample_valid` is produced; `sample` and `overrange` hold their last values.
  - Re-enabling always passes through DISCHARGE before RAMP.
- **Strobe.** `sample_valid` is high for exactly one cycle per conversion and is never asserted in IDLE or DISCHARGE.

## Timing
- **Reset** (asynchronous, immediate):
  - state = IDLE.
  - `pwm_out` = 0, `sample` = 0, `sample_valid` = 0, `overrange` = 0.
  - Sync flops = 0, all counters = 0.
  - Reset mid-conversion discards the conversion with no strobe.
- **Trip latency.** `comp_in` first sampled high at edge t → `comp_s` high after edge t+1 → `sample`/`sample_valid` update at edge t+2.
  - `sample_valid` is visible in the cycle after edge t+2.
  - `pwm_out` is 0 from the cycle after edge t+3.
- **Captured value.** The captured code is the `duty` value in the cycle `comp_s` is high, not the value when `comp_in` rose.
- **Conversion time** for code c (from DISCHARGE entry): DISCHARGE_PERIODS·256 + c·SETTLE_PERIODS·256 + (0..255 within the step) + 2 sync cycles.
- **Overrange conversion time:** DISCHARGE_PERIODS·256 + 256·SETTLE_PERIODS·256 cycles.
- **Enable response.** `enable` falling: `pwm_out` is 0 by the second edge after the fall.

## Test plan
- **Reset.** Assert `reset` asynchronously mid-RAMP with `duty` = 50 → all outputs 0 immediately, with no clock edge. Release → IDLE; with `enable` = 1 the block enters DISCHARGE.
- **Normal trip.** Defaults; raise `comp_in` when `duty` = 100 → `sample` = 100, `overrange` = 0, one-cycle `sample_valid` 3 edges after the rise. Then `pwm_out` low for 1024 cycles, and the next ramp starts at `duty` 0.
- **Full-scale ramp.** `comp_in` held 0 → after 1024 + 65536 cycles: `sample` = 255, `overrange` = 1, single strobe. Next trip at `duty` 10 → `overrange` = 0.
- **Zero input.** `comp_in` held 1 → `sample` = 0 every conversion, one strobe per 1024 + ~3 cycles.
- **Enable drop and discharge glitches.** Drop `enable` at `duty` = 40 → no strobe, `sample` unchanged, `pwm_out` 0 within 2 cycles. Re-enable → 1024 cycles low before the ramp. Pulse `comp_in` during DISCHARGE → ignored.
- **Step boundary and PWM duty.** With `SETTLE_PERIODS` = 2, raise `comp_in` so `comp_s` rises exactly on the period end that steps 7→8 → `sample` = 7. Count `pwm_out` high-time per period at `duty` = 7 → exactly 7 clocks.

Source files
------------

// File: rtl/pwm_ramp_adc.sv
// PWM ramp ADC front end: steps a PWM duty code into an external RC filter and
// captures the code at which the synchronized comparator output goes high.
module pwm_ramp_adc #(
   parameter int SETTLE_PERIODS    = 1,
   parameter int DISCHARGE_PERIODS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       comp_in,
   output logic       pwm_out,
   output logic [7:0] sample,
   output logic       sample_valid,
   output logic       overrange
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] DISCHARGE = 2'd1;
   localparam logic [1:0] RAMP      = 2'd2;

   localparam logic [7:0] SETTLE_LAST    = 8'(SETTLE_PERIODS - 1);
   localparam logic [7:0] DISCHARGE_LAST = 8'(DISCHARGE_PERIODS - 1);

   logic [1:0] state_q, state_d;
   logic       sync1_q, comp_s_q;
   logic [7:0] pwm_cnt_q, pwm_cnt_d;
   logic [7:0] period_cnt_q, period_cnt_d;
   logic [7:0] duty_q, duty_d;
   logic       pwm_out_q, pwm_out_d;
   logic [7:0] sample_q, sample_d;
   logic       sample_valid_q, sample_valid_d;
   logic       overrange_q, overrange_d;
   logic       period_end;
   logic       step_due;

   assign period_end = (pwm_cnt_q == 8'hFF);
   assign step_due   = period_end && (period_cnt_q == SETTLE_LAST);

   // Two-flop synchronizer; only comp_s_q is ever looked at by the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         comp_s_q <= 1'b0;
      end else begin
         sync1_q  <= comp_in;
         comp_s_q <= sync1_q;
      end
   end

   always_comb begin
      state_d        = state_q;
      pwm_cnt_d      = pwm_cnt_q + 8'd1;
      period_cnt_d   = period_cnt_q;
      duty_d         = duty_q;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      overrange_d    = overrange_q;
      pwm_out_d      = (state_q == RAMP) && (pwm_cnt_q < duty_q);

      if (!enable) begin
         state_d      = IDLE;
         pwm_cnt_d    = 8'd0;
         period_cnt_d = 8'd0;
         duty_d       = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d      = DISCHARGE;
               pwm_cnt_d    = 8'd0;
               period_cnt_d = 8'd0;
               duty_d       = 8'd0;
            end
            DISCHARGE: begin
               duty_d = 8'd0;
               if (period_end) begin
                  if (period_cnt_q == DISCHARGE_LAST) begin
                     state_d      = RAMP;
                     period_cnt_d = 8'd0;
                  end else begin
                     period_cnt_d = period_cnt_q + 8'd1;
                  end
               end
            end
            RAMP: begin
               // A trip beats a coincident step, so the pre-step code is kept.
               if (comp_s_q || (step_due && (duty_q == 8'hFF))) begin
                  sample_d       = comp_s_q ? duty_q : 8'hFF;
                  overrange_d    = !comp_s_q;
                  sample_valid_d = 1'b1;
                  state_d        = DISCHARGE;
                  pwm_cnt_d      = 8'd0;
                  period_cnt_d   = 8'd0;
                  duty_d         = 8'd0;
               end else if (step_due) begin
                  period_cnt_d = 8'd0;
                  duty_d       = duty_q + 8'd1;
               end else if (period_end) begin
                  period_cnt_d = period_cnt_q + 8'd1;
               end
            end
            default: begin
               state_d      = IDLE;
               pwm_cnt_d    = 8'd0;
               period_cnt_d = 8'd0;
               duty_d       = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         pwm_cnt_q      <= 8'd0;
         period_cnt_q   <= 8'd0;
         duty_q         <= 8'd0;
         pwm_out_q      <= 1'b0;
         sample_q       <= 8'd0;
         sample_valid_q <= 1'b0;
         overrange_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         pwm_cnt_q      <= pwm_cnt_d;
         period_cnt_q   <= period_cnt_d;
         duty_q         <= duty_d;
         pwm_out_q      <= pwm_out_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         overrange_q    <= overrange_d;
      end
   end

   assign pwm_out      = pwm_out_q;
   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign overrange    = overrange_q;

endmodule

// File: tb/tb_pwm_ramp_adc.sv
// Bench for pwm_ramp_adc: three instances run in parallel (full-scale ramp,
// general conversions/disable/reset, and a two-period settle configuration).
module tb_pwm_ramp_adc;

   typedef struct {
      logic [7:0] sample;
      logic       over;
   } expect_t;

   typedef struct {
      int         code;
      logic [7:0] expSample;
      logic       expOver;
   } vector_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstA, enA, compA, pwmA, validA, overA;
   logic [7:0] sampleA;
   logic       rstB, enB, compB, pwmB, validB, overB;
   logic [7:0] sampleB;
   logic       rstC, enC, compC, pwmC, validC, overC;
   logic [7:0] sampleC;

   int nCompared;
   int nMismatched;

   expect_t qA[$];
   expect_t qB[$];
   expect_t qC[$];
   vector_t vectors[4];

   pwm_ramp_adc dutA (
      .clk(clk), .reset(rstA), .enable(enA), .comp_in(compA),
      .pwm_out(pwmA), .sample(sampleA), .sample_valid(validA), .overrange(overA)
   );

   pwm_ramp_adc dutB (
      .clk(clk), .reset(rstB), .enable(enB), .comp_in(compB),
      .pwm_out(pwmB), .sample(sampleB), .sample_valid(validB), .overrange(overB)
   );

   pwm_ramp_adc #(.SETTLE_PERIODS(2), .DISCHARGE_PERIODS(2)) dutC (
      .clk(clk), .reset(rstC), .enable(enC), .comp_in(compC),
      .pwm_out(pwmC), .sample(sampleC), .sample_valid(validC), .overrange(overC)
   );

   // Every comparison funnels through here so the counts stay consistent.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      nCompared++;
      if (act !== want) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic expect_t mkExp(input logic [7:0] s, input logic o);
      expect_t e;
      e.sample = s;
      e.over   = o;
      return e;
   endfunction

   function automatic vector_t mkVec(input int code);
      vector_t v;
      v.code      = code;
      v.expSample = 8'(code);
      v.expOver   = 1'b0;
      return v;
   endfunction

   task automatic countPwmB(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (pwmB) cnt++;
      end
   endtask

   // Called on the negedge right after the DISCHARGE-entry edge plus 'already'
   // negedges; raises the comparator mid-step of 'code' and checks the latency.
   task automatic applyStimulus(input int code, input int already,
                                input logic [7:0] expSample, input logic expOver);
      int k;
      k = 1024 + 256 * code + 128;
      tick(k - already);
      qB.push_back(mkExp(expSample, expOver));
      compB = 1'b1;
      tick(2);
      checkOutput("B valid before latency", 32'(validB), 32'd0);
      tick(1);
      checkOutput("B valid at latency", 32'(validB), 32'd1);
      compB = 1'b0;
   endtask

   // Scoreboards: each strobe must match the oldest pending expectation.
   always @(negedge clk) begin
      expect_t e;
      if (validA) begin
         checkOutput("A strobe pending", 32'(qA.size() != 0), 32'd1);
         if (qA.size() != 0) begin
            e = qA.pop_front();
            checkOutput("A sample", 32'(sampleA), 32'(e.sample));
            checkOutput("A overrange", 32'(overA), 32'(e.over));
         end
      end
   end

   always @(negedge clk) begin
      expect_t e;
      if (validB) begin
         checkOutput("B strobe pending", 32'(qB.size() != 0), 32'd1);
         if (qB.size() != 0) begin
            e = qB.pop_front();
            checkOutput("B sample", 32'(sampleB), 32'(e.sample));
            checkOutput("B overrange", 32'(overB), 32'(e.over));
         end
      end
   end

   always @(negedge clk) begin
      expect_t e;
      if (validC) begin
         checkOutput("C strobe pending", 32'(qC.size() != 0), 32'd1);
         if (qC.size() != 0) begin
            e = qC.pop_front();
            checkOutput("C sample", 32'(sampleC), 32'(e.sample));
            checkOutput("C overrange", 32'(overC), 32'(e.over));
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rstA = 1'b1; enA = 1'b0; compA = 1'b0;
      rstB = 1'b1; enB = 1'b0; compB = 1'b0;
      rstC = 1'b1; enC = 1'b0; compC = 1'b0;
      vectors[0] = mkVec(2);
      vectors[1] = mkVec(0);
      vectors[2] = mkVec(1);
      vectors[3] = mkVec(5);

      tick(2);
      rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
      tick(1);
      checkOutput("B reset pwm_out", 32'(pwmB), 32'd0);
      checkOutput("B reset sample", 32'(sampleB), 32'd0);
      checkOutput("B reset sample_valid", 32'(validB), 32'd0);
      checkOutput("B reset overrange", 32'(overB), 32'd0);

      fork
         begin : procA
            enA = 1'b1;
            tick(1);
            qA.push_back(mkExp(8'd255, 1'b1));
            tick(1024 + 65536 - 1);
            checkOutput("A no strobe before full scale", 32'(validA), 32'd0);
            checkOutput("A overrange before full scale", 32'(overA), 32'd0);
            tick(1);
            checkOutput("A strobe at full scale", 32'(validA), 32'd1);
            tick(1);
            checkOutput("A strobe one cycle", 32'(validA), 32'd0);
            tick(1024 + 10 * 256 + 128 - 1);
            qA.push_back(mkExp(8'd10, 1'b0));
            compA = 1'b1;
            tick(3);
            checkOutput("A strobe after trip", 32'(validA), 32'd1);
            compA = 1'b0;
            tick(1);
            checkOutput("A overrange cleared", 32'(overA), 32'd0);
         end

         begin : procB
            int cnt;
            int cntPre;
            int cntPulse;
            int already;
            enB = 1'b1;
            tick(1);
            applyStimulus(100, 0, 8'd100, 1'b0);
            countPwmB(1280, cnt);
            checkOutput("B pwm low through discharge", cnt, 0);
            countPwmB(256, cnt);
            checkOutput("B first ramp step high time", cnt, 1);

            already = 1536;
            for (int i = 0; i < 4; i++) begin
               applyStimulus(vectors[i].code, already, vectors[i].expSample, vectors[i].expOver);
               already = 0;
               checkOutput("B vector sample", 32'(sampleB), 32'(vectors[i].expSample));
            end

            // Comparator rises so its trip edge coincides with the disable edge.
            tick(1024 + 40 * 256 + 10 - 2);
            compB = 1'b1;
            tick(2);
            checkOutput("B pwm high before disable", 32'(pwmB), 32'd1);
            enB = 1'b0;
            tick(2);
            checkOutput("B pwm low after disable", 32'(pwmB), 32'd0);
            compB = 1'b0;
            tick(4);
            checkOutput("B sample held after disable", 32'(sampleB), 32'd5);
            checkOutput("B overrange held after disable", 32'(overB), 32'd0);

            enB = 1'b1;
            tick(1);
            countPwmB(500, cntPre);
            compB = 1'b1;
            countPwmB(3, cntPulse);
            compB = 1'b0;
            countPwmB(777, cnt);
            checkOutput("B pwm low after re-enable", cntPre + cntPulse + cnt, 0);
            countPwmB(256, cnt);
            checkOutput("B re-enable first step high time", cnt, 1);

            tick(1024 + 50 * 256 + 20 - 1536);
            checkOutput("B pwm high before reset", 32'(pwmB), 32'd1);
            #2 rstB = 1'b1;
            #1;
            checkOutput("B async reset pwm_out", 32'(pwmB), 32'd0);
            checkOutput("B async reset sample", 32'(sampleB), 32'd0);
            checkOutput("B async reset sample_valid", 32'(validB), 32'd0);
            checkOutput("B async reset overrange", 32'(overB), 32'd0);
            @(negedge clk);
            rstB = 1'b0;
            tick(1);

            compB = 1'b1;
            for (int i = 0; i < 3; i++) begin
               qB.push_back(mkExp(8'd0, 1'b0));
               tick(1024);
               checkOutput("B zero input no early strobe", 32'(validB), 32'd0);
               tick(1);
               checkOutput("B zero input strobe", 32'(validB), 32'd1);
            end
            compB = 1'b0;
         end

         begin : procC
            int c0, c1, c6, c7a, c7b;
            c0 = 0; c1 = 0; c6 = 0; c7a = 0; c7b = 0;
            enC = 1'b1;
            tick(1);
            for (int n = 1; n <= 4608; n++) begin
               @(negedge clk);
               if (n == 4605) begin
                  qC.push_back(mkExp(8'd7, 1'b0));
                  compC = 1'b1;
               end
               if (pwmC) begin
                  if (n <= 1024) c0++;
                  else if (n <= 1280) c1++;
                  else if (n >= 3585 && n <= 3840) c6++;
                  else if (n >= 4097 && n <= 4352) c7a++;
                  else if (n >= 4353) c7b++;
               end
            end
            checkOutput("C strobe on step boundary", 32'(validC), 32'd1);
            compC = 1'b0;
            checkOutput("C pwm low through discharge and duty 0", c0, 0);
            checkOutput("C high time duty 1", c1, 1);
            checkOutput("C high time duty 6", c6, 6);
            checkOutput("C high time duty 7 period 1", c7a, 7);
            checkOutput("C high time duty 7 period 2", c7b, 7);
         end
      join

      tick(5);
      checkOutput("A expectations drained", 32'(qA.size()), 32'd0);
      checkOutput("B expectations drained", 32'(qB.size()), 32'd0);
      checkOutput("C expectations drained", 32'(qC.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
